// File: rtl/execute_stage_pkg.sv
`default_nettype none
// ============================================================================
// cpu_defs : ALU/md opcodes, HI/LO addresses and md FSM states for the core
// Rev 1.0
// ============================================================================
package cpu_defs;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SAL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    localparam logic [5:0] HI_ADDR = 6'b100001;
    localparam logic [5:0] LO_ADDR = 6'b100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// execute_stage_if : data-SRAM request bus driven by the execute stage
// Rev 1.0
// ============================================================================
interface execute_stage_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;

    modport master (output en, output wen, output addr, output wdata);
    modport slave  (input  en, input  wen, input  addr, input  wdata);
endinterface
`default_nettype wire

// File: rtl/execute_stage_md.sv
`default_nettype none
// ============================================================================
// md_unit : multi-cycle multiply / restoring divide producing HI/LO
// Rev 1.0
// ============================================================================
module md_unit
    import cpu_defs::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  md_op,
    input  logic        md_signed,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    md_state_t   r_state;
    logic [CW-1:0] r_count;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic [31:0] r_dividend;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;
    logic        r_hilo_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_prod;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_hi_final;
    logic [31:0] w_lo_final;

    always_comb begin
        if (md_signed)
            w_prod = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});
        else
            w_prod = {32'b0, src1} * {32'b0, src2};
    end

    assign w_mag_a = (md_signed && src1[31]) ? (32'd0 - src1) : src1;
    assign w_mag_b = (md_signed && src2[31]) ? (32'd0 - src2) : src2;

    // Restoring step: shift next dividend bit into the partial remainder.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? (w_shift[31:0] - r_divisor) : w_shift[31:0];
    assign w_quo_next = {r_quo[30:0], w_ge};

    // A zero divisor returns all-ones / original dividend, bypassing sign fix-up.
    assign w_lo_final = r_div_zero ? 32'hFFFF_FFFF :
                        (r_neg_q ? (32'd0 - w_quo_next) : w_quo_next);
    assign w_hi_final = r_div_zero ? r_dividend :
                        (r_neg_r ? (32'd0 - w_rem_next) : w_rem_next);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_dividend <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hilo_we  <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_hilo_we <= 1'b0;
                    if (md_op == MD_MULT) begin
                        r_state   <= ST_DONE;
                        r_hilo_we <= 1'b1;
                        r_hi      <= w_prod[63:32];
                        r_lo      <= w_prod[31:0];
                    end else if (md_op == MD_DIV) begin
                        r_state    <= ST_DIV;
                        r_count    <= '0;
                        r_rem      <= '0;
                        r_quo      <= w_mag_a;
                        r_divisor  <= w_mag_b;
                        r_dividend <= src1;
                        r_neg_q    <= md_signed & (src1[31] ^ src2[31]);
                        r_neg_r    <= md_signed & src1[31];
                        r_div_zero <= (src2 == 32'd0);
                    end
                end
                ST_DIV: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(DIV_CYCLES - 1)) begin
                        r_state   <= ST_DONE;
                        r_hilo_we <= 1'b1;
                        r_hi      <= w_hi_final;
                        r_lo      <= w_lo_final;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_hilo_we <= 1'b0;
                    r_count   <= '0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_hilo_we <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign hilo_we = r_hilo_we;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// execute_stage : ALU, data-SRAM request, EX/MEM register and md unit
// Rev 1.0
// ============================================================================
module execute_stage
    import cpu_defs::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [3:0]   de_aluop,
    input  logic [31:0]  de_alusrc1,
    input  logic [31:0]  de_alusrc2,
    input  logic [1:0]   de_md_op,
    input  logic         de_md_signed,
    input  logic         de_mem_en,
    input  logic         de_mem_read,
    input  logic [3:0]   de_mem_wen,
    input  logic [31:0]  de_mem_wdata,
    input  logic         de_reg_en,
    input  logic [5:0]   de_reg_waddr,
    execute_stage_if.master data_sram,
    output logic         exe_reg_en,
    output logic         exe_mem_read,
    output logic [5:0]   exe_reg_waddr,
    output logic [31:0]  exe_alu_result,
    output logic         exe_busy,
    output logic         exe_hilo_we,
    output logic [31:0]  exe_hi,
    output logic [31:0]  exe_lo
);

    logic [31:0] w_alu;
    logic [4:0]  w_sa;
    logic        w_busy;

    logic        r_reg_en;
    logic        r_mem_read;
    logic [5:0]  r_reg_waddr;
    logic [31:0] r_alu_result;

    assign w_sa = de_alusrc1[4:0];

    always_comb begin
        w_alu = 32'd0;
        case (de_aluop)
            ALU_AND:  w_alu = de_alusrc1 & de_alusrc2;
            ALU_OR:   w_alu = de_alusrc1 | de_alusrc2;
            ALU_ADD:  w_alu = de_alusrc1 + de_alusrc2;
            ALU_SUB:  w_alu = de_alusrc1 - de_alusrc2;
            ALU_SLT:  w_alu = {31'd0, $signed(de_alusrc1) < $signed(de_alusrc2)};
            ALU_SLTU: w_alu = {31'd0, de_alusrc1 < de_alusrc2};
            ALU_SLL,
            ALU_SAL:  w_alu = de_alusrc2 << w_sa;
            ALU_SRL:  w_alu = de_alusrc2 >> w_sa;
            ALU_SRA:  w_alu = $unsigned($signed(de_alusrc2) >>> w_sa);
            ALU_LUI:  w_alu = {de_alusrc2[15:0], 16'd0};
            ALU_XOR:  w_alu = de_alusrc1 ^ de_alusrc2;
            ALU_NOR:  w_alu = ~(de_alusrc1 | de_alusrc2);
            default:  w_alu = 32'd0;
        endcase
    end

    // No new memory request may issue while the md unit holds the pipe.
    assign data_sram.en    = de_mem_en & ~w_busy;
    assign data_sram.wen   = w_busy ? 4'b0000 : de_mem_wen;
    assign data_sram.addr  = w_alu;
    assign data_sram.wdata = de_mem_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_reg_en     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_reg_waddr  <= 6'd0;
            r_alu_result <= 32'd0;
        end else begin
            r_reg_en     <= de_reg_en & ~w_busy;
            r_mem_read   <= de_mem_read & ~w_busy;
            r_reg_waddr  <= de_reg_waddr;
            r_alu_result <= w_alu;
        end
    end

    md_unit #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_unit (
        .clk       (clk),
        .resetn    (resetn),
        .md_op     (de_md_op),
        .md_signed (de_md_signed),
        .src1      (de_alusrc1),
        .src2      (de_alusrc2),
        .busy      (w_busy),
        .hilo_we   (exe_hilo_we),
        .hi        (exe_hi),
        .lo        (exe_lo)
    );

    assign exe_busy       = w_busy;
    assign exe_reg_en     = r_reg_en;
    assign exe_mem_read   = r_mem_read;
    assign exe_reg_waddr  = r_reg_waddr;
    assign exe_alu_result = r_alu_result;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// tb_execute_stage : directed + random checks of execute_stage vs a model
// Rev 1.0
// ============================================================================
module tb_execute_stage;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  de_aluop;
    logic [31:0] de_alusrc1, de_alusrc2;
    logic [1:0]  de_md_op;
    logic        de_md_signed;
    logic        de_mem_en, de_mem_read;
    logic [3:0]  de_mem_wen;
    logic [31:0] de_mem_wdata;
    logic        de_reg_en;
    logic [5:0]  de_reg_waddr;
    logic        exe_reg_en, exe_mem_read, exe_busy, exe_hilo_we;
    logic [5:0]  exe_reg_waddr;
    logic [31:0] exe_alu_result, exe_hi, exe_lo;

    int checks = 0;
    int errors = 0;

    execute_stage_if sram_bus ();

    execute_stage #(.DIV_CYCLES(32)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .de_aluop       (de_aluop),
        .de_alusrc1     (de_alusrc1),
        .de_alusrc2     (de_alusrc2),
        .de_md_op       (de_md_op),
        .de_md_signed   (de_md_signed),
        .de_mem_en      (de_mem_en),
        .de_mem_read    (de_mem_read),
        .de_mem_wen     (de_mem_wen),
        .de_mem_wdata   (de_mem_wdata),
        .de_reg_en      (de_reg_en),
        .de_reg_waddr   (de_reg_waddr),
        .data_sram      (sram_bus),
        .exe_reg_en     (exe_reg_en),
        .exe_mem_read   (exe_mem_read),
        .exe_reg_waddr  (exe_reg_waddr),
        .exe_alu_result (exe_alu_result),
        .exe_busy       (exe_busy),
        .exe_hilo_we    (exe_hilo_we),
        .exe_hi         (exe_hi),
        .exe_lo         (exe_lo)
    );

    always #5 clk = ~clk;

    // Decode must never issue a new md op while the unit is occupied.
    always @(negedge clk) begin
        if (resetn && exe_busy && de_md_op != MD_NONE) begin
            errors++;
            $error("FAIL protocol md_op=%0d issued while busy", de_md_op);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = a % 32;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a - b;
            4'd4:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6,
            4'd8:  return b * (32'd1 << sh);
            4'd7:  return b / (32'd1 << sh);
            4'd9: begin
                r = b / (32'd1 << sh);
                if (b[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                return r;
            end
            4'd10: return b * 32'd65536;
            4'd11: return a ^ b;
            4'd12: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_ref(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = sgn ? longint'(int'(a)) : longint'({32'd0, a});
        sb = sgn ? longint'(int'(b)) : longint'({32'd0, b});
        if (op == MD_MULT) begin
            p  = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end
    endtask

    task automatic idle_inputs();
        de_aluop = 4'd0; de_alusrc1 = 32'd0; de_alusrc2 = 32'd0;
        de_md_op = MD_NONE; de_md_signed = 1'b0;
        de_mem_en = 1'b0; de_mem_read = 1'b0; de_mem_wen = 4'd0; de_mem_wdata = 32'd0;
        de_reg_en = 1'b0; de_reg_waddr = 6'd0;
    endtask

    task automatic alu_step(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp,
                            input logic men, input logic mrd, input logic [3:0] wen,
                            input logic ren, input logic [5:0] wa);
        logic [31:0] wd;
        wd = $urandom;
        de_aluop = op; de_alusrc1 = a; de_alusrc2 = b;
        de_mem_en = men; de_mem_read = mrd; de_mem_wen = wen; de_mem_wdata = wd;
        de_reg_en = ren; de_reg_waddr = wa;
        #1;
        chk({tag, "_addr"}, sram_bus.addr, exp);
        chk({tag, "_en"}, 32'(sram_bus.en), 32'(men));
        chk({tag, "_wen"}, 32'(sram_bus.wen), 32'(wen));
        chk({tag, "_wdata"}, sram_bus.wdata, wd);
        @(posedge clk); #1;
        chk({tag, "_result"}, exe_alu_result, exp);
        chk({tag, "_reg_en"}, 32'(exe_reg_en), 32'(ren));
        chk({tag, "_mem_read"}, 32'(exe_mem_read), 32'(mrd));
        chk({tag, "_waddr"}, 32'(exe_reg_waddr), 32'(wa));
    endtask

    task automatic do_md(input string tag, input logic [1:0] op, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el, gh, gl;
        int busy_n, we_n, exp_busy;
        md_ref(op, sgn, a, b, eh, el);
        exp_busy = (op == MD_DIV) ? 33 : 1;
        idle_inputs();
        de_md_op = op; de_md_signed = sgn; de_alusrc1 = a; de_alusrc2 = b;
        @(posedge clk); #1;
        de_md_op = MD_NONE; de_mem_en = 1'b1; de_mem_wen = 4'hF;
        de_reg_en = 1'b1; de_mem_read = 1'b1; de_reg_waddr = 6'd5;
        busy_n = 0; we_n = 0; gh = 32'd0; gl = 32'd0;
        while (exe_busy && busy_n < 100) begin
            chk({tag, "_sram_en_busy"}, 32'(sram_bus.en), 32'd0);
            chk({tag, "_sram_wen_busy"}, 32'(sram_bus.wen), 32'd0);
            chk({tag, "_reg_en_bubble"}, 32'(exe_reg_en), 32'd0);
            if (exe_hilo_we) begin
                we_n++; gh = exe_hi; gl = exe_lo;
            end
            busy_n++;
            @(posedge clk); #1;
        end
        chk({tag, "_busy_cycles"}, busy_n, exp_busy);
        chk({tag, "_hilo_we_pulses"}, we_n, 32'd1);
        chk({tag, "_hi"}, gh, eh);
        chk({tag, "_lo"}, gl, el);
        chk({tag, "_hilo_we_after"}, 32'(exe_hilo_we), 32'd0);
        idle_inputs();
    endtask

    initial begin
        int we_seen;
        logic [3:0] rop;
        logic [31:0] ra, rb;
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(exe_busy), 32'd0);
        chk("rst_hilo_we", 32'(exe_hilo_we), 32'd0);
        chk("rst_reg_en", 32'(exe_reg_en), 32'd0);
        chk("rst_mem_read", 32'(exe_mem_read), 32'd0);
        chk("rst_waddr", 32'(exe_reg_waddr), 32'd0);
        chk("rst_result", exe_alu_result, 32'd0);
        chk("rst_hi", exe_hi, 32'd0);
        chk("rst_lo", exe_lo, 32'd0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        alu_step("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 4'h0, 1, 6'd3);
        alu_step("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 4'h0, 1, 6'd4);
        alu_step("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 4'h0, 1, 6'd5);
        alu_step("sra", ALU_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000, 0, 0, 4'h0, 1, 6'd6);
        alu_step("lui", ALU_LUI, 32'd0, 32'h0000_1234, 32'h1234_0000, 0, 0, 4'h0, 1, 6'd7);
        alu_step("unk", 4'b1110, 32'h55, 32'hAA, 32'd0, 0, 0, 4'h0, 1, 6'd8);
        alu_step("store", ALU_ADD, 32'h100, 32'd4, 32'h104, 1, 0, 4'hF, 0, 6'd0);
        alu_step("load", ALU_ADD, 32'h200, 32'h10, 32'h210, 1, 1, 4'h0, 1, 6'd9);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom; rb = $urandom;
            alu_step("rand_alu", rop, ra, rb, alu_ref(rop, ra, rb), 1'($urandom),
                     1'($urandom), 4'($urandom), 1'($urandom), 6'($urandom));
        end
        idle_inputs();

        do_md("mult_s", MD_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7);
        chk("mult_s_hi_val", exe_hi, 32'hFFFF_FFFF);
        chk("mult_s_lo_val", exe_lo, 32'hFFFF_FFEB);
        do_md("mult_u", MD_MULT, 1'b0, 32'hFFFF_FFFD, 32'd7);
        chk("mult_u_hi_val", exe_hi, 32'd6);
        do_md("div_s", MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div_s_lo_val", exe_lo, 32'hFFFF_FFFD);
        chk("div_s_hi_val", exe_hi, 32'hFFFF_FFFF);
        do_md("divu_zero", MD_DIV, 1'b0, 32'd10, 32'd0);
        chk("divu_zero_lo_val", exe_lo, 32'hFFFF_FFFF);
        chk("divu_zero_hi_val", exe_hi, 32'd10);
        do_md("divs_zero", MD_DIV, 1'b1, 32'hFFFF_FFF0, 32'd0);

        // Abort a divide with an asynchronous reset part-way through.
        de_md_op = MD_DIV; de_md_signed = 1'b0; de_alusrc1 = 32'd1000; de_alusrc2 = 32'd3;
        @(posedge clk); #1;
        idle_inputs();
        repeat (15) @(posedge clk);
        #1;
        chk("rst_mid_busy_before", 32'(exe_busy), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(exe_busy), 32'd0);
        chk("rst_mid_hilo_we", 32'(exe_hilo_we), 32'd0);
        chk("rst_mid_hi", exe_hi, 32'd0);
        chk("rst_mid_lo", exe_lo, 32'd0);
        @(negedge clk); resetn = 1'b1;
        we_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (exe_hilo_we || exe_busy) we_seen++;
        end
        chk("rst_mid_no_hilo", we_seen, 32'd0);
        do_md("divu_after_rst", MD_DIV, 1'b0, 32'd100, 32'd7);
        chk("divu_after_rst_lo_val", exe_lo, 32'd14);
        chk("divu_after_rst_hi_val", exe_hi, 32'd2);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            do_md("rand_mult", MD_MULT, 1'($urandom), ra, rb);
        end
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            if (i % 2 == 1 && ra[0]) rb = 32'd0 - rb;
            do_md("rand_div", MD_DIV, 1'($urandom), ra, rb);
        end

        // Regular ALU op issued in the same cycle as a MULT is accepted.
        de_md_op = MD_MULT; de_md_signed = 1'b0; de_aluop = ALU_OR;
        de_alusrc1 = 32'h0F0F_0000; de_alusrc2 = 32'h0000_00F0;
        de_reg_en = 1'b1; de_reg_waddr = 6'd12;
        @(posedge clk); #1;
        chk("accept_alu_result", exe_alu_result, 32'h0F0F_00F0);
        chk("accept_alu_reg_en", 32'(exe_reg_en), 32'd1);
        idle_inputs();
        @(posedge clk); #1;
        chk("accept_busy_done", 32'(exe_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
# execute_stage

Third pipeline stage of the 5-stage MIPS core: consumes the registered control/operand bundle from the decode stage, evaluates the ALU, drives the data-SRAM request for loads/stores, and registers results for the memory stage. A multi-cycle multiply/divide unit computes HI/LO results and raises `exe_busy` to the hazard unit while occupied.

## Interface
- `DIV_CYCLES`, 32: iterations of the restoring divider (one quotient bit per cycle).
- `clk` in 1: pipeline clock, all state on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `de_aluop` in 4: ALU op; AND 0000, OR 0001, ADD 0010, SUB 0011, SLT 0100, SLTU 0101, SLL 0110, SRL 0111, SAL 1000, SRA 1001, LUI 1010, XOR 1011, NOR 1100.
- `de_alusrc1`, `de_alusrc2` in 32: ALU operands; src1 carries the shift amount for shifts.
- `de_md_op` in 2: 00 none, 01 MULT, 10 DIV.
- `de_md_signed` in 1: signed (1) / unsigned (0) mult/div.
- `de_mem_en`, `de_mem_read` in 1; `de_mem_wen` in 4; `de_mem_wdata` in 32.
- `de_reg_en` in 1; `de_reg_waddr` in 6.
- `data_sram_en` out 1; `data_sram_wen` out 4; `data_sram_addr` out 32; `data_sram_wdata` out 32.
- `exe_reg_en`, `exe_mem_read` out 1; `exe_reg_waddr` out 6; `exe_alu_result` out 32: registered to memory stage.
- `exe_busy` out 1: md unit occupied; hazard unit must stall decode.
- `exe_hilo_we` out 1; `exe_hi`, `exe_lo` out 32: HI/LO write port to register file (HI addr 6'b100001, LO 6'b100000).

## Operation
- ALU combinational on `de_alusrc*`. Shifts: value src2, amount src1[4:0]; SAL identical to SLL; SRA arithmetic. LUI = src2 << 16. SLT signed, SLTU unsigned, result 0/1. ADD/SUB 32-bit wrap, no overflow trap. Unknown codes 1101-1111 -> 0.
- Data SRAM: `data_sram_en`=de_mem_en, `wen`=de_mem_wen, `addr`=ALU result, `wdata`=de_mem_wdata; en and wen forced 0 while `exe_busy`.
- Pipeline register: alu_result, reg_en, mem_read, reg_waddr captured every edge; while `exe_busy`, reg_en and mem_read captured as 0 (bubble).
- md FSM states IDLE, DIV, DONE:
  - IDLE + md_op=MULT -> DONE; 64-bit product (signed per de_md_signed) latched, HI=[63:32], LO=[31:0].
  - IDLE + md_op=DIV -> DIV, counter=0, operands latched as magnitudes (signed) or raw (unsigned); src1 dividend, src2 divisor.
  - DIV: one restoring step per cycle; counter==DIV_CYCLES-1 -> DONE.
  - DONE: `exe_hilo_we`=1, `exe_hi`/`exe_lo` valid; -> IDLE next edge.
- Divide: LO=quotient, HI=remainder; signed quotient negated if operand signs differ, remainder takes dividend sign. Divisor 0: LO=32'hFFFF_FFFF, HI=dividend, regardless of signedness.
- `exe_busy` = state != IDLE. md_op != 00 while busy is a protocol violation: ignored, bench asserts it never occurs.

## Timing
- Reset: state IDLE, counter 0; `exe_reg_en`, `exe_mem_read`, `exe_hilo_we`, `exe_busy` 0; `exe_reg_waddr`, `exe_alu_result`, `exe_hi`, `exe_lo` 0.
- ALU/SRAM request: same cycle as operands; memory-stage outputs 1 cycle latency.
- MULT: accepted edge E0; DONE in E0..E1 cycle; busy 1 cycle; HI/LO written at E1.
- DIV: DIV state 32 cycles, DONE 1 cycle; busy 33 cycles; HI/LO written at E0+33.
- Reset mid-divide: abort to IDLE, no `exe_hilo_we` pulse.
- ALU instruction in the accept cycle of MULT/DIV proceeds normally (md instrs carry reg_en=0).

## Structure
- Package `cpu_defs`: ALU opcodes, md_op codes, HI/LO register addresses, FSM state enum; shared with decode and hazard unit.
- Sub-module `md_unit`: FSM, counter, restoring divider, multiplier, sign correction; top holds ALU, SRAM drive, pipeline register.

## Test plan
- ALU sweep: SUB 5-7 -> 32'hFFFF_FFFE; SLT 32'hFFFF_FFFF vs 1 -> 1, SLTU -> 0; SRA src1=4, src2=32'h8000_0000 -> 32'hF800_0000; LUI 16'h1234 -> 32'h1234_0000.
- Store: mem_en=1, wen=1111, src1=0x100, src2=4 -> sram addr 0x104 same cycle, reg_en out 0.
- MULT signed -3 x 7 -> busy 1 cycle, hilo_we with HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB; unsigned same operands -> HI=6.
- DIV signed -7/2 -> after 33 busy cycles LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; SRAM en forced 0 and reg_en bubble throughout.
- DIVU 10/0 -> LO=32'hFFFF_FFFF, HI=10.
- Reset at DIV cycle 15 -> busy 0 immediately, no hilo_we; next DIVU 100/7 -> LO=14, HI=2.
